lfsr_stream_checker: RTL and testbench



---
 rtl/lfsr_stream_checker.sv | 78 +++++++
 tb/tb_lfsr_stream_checker.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: self-synchronising checker for the 13-bit game LFSR serial stream.
module lfsr_stream_checker #(
  parameter int LOCK_LEN    = 32,
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_counts,
  output logic             locked,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      bit_count,
  output logic [7:0]       loss_count
);
  localparam logic [1:0] HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2;
  localparam int MW = $clog2(LOCK_LEN + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int EW = $clog2(LOSS_THRESH + 1);
  logic [1:0]    next_state;
  logic [12:0]   sr;
  logic [3:0]    fill_cnt;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_bits;
  logic [EW-1:0] win_err, win_err_nxt;
  logic          exp_bit, match, mismatch, lose, fill_done, lock_done, win_end, in_lock;
  always_comb begin
    exp_bit     = sr[12] ^ sr[3] ^ sr[2] ^ sr[0];
    in_lock     = state == LOCKED;
    match       = bit_in == exp_bit && sr != '0;
    mismatch    = bit_valid && in_lock && bit_in != exp_bit;
    win_err_nxt = win_err + EW'(mismatch);
    fill_done   = fill_cnt == 4'd12;
    lock_done   = match_cnt == MW'(LOCK_LEN - 1);
    win_end     = win_bits == WW'(WIN_LEN - 1);
    lose        = mismatch && win_err_nxt == EW'(LOSS_THRESH);
  end
  always_ff @(posedge clock)
    state <= reset ? HUNT : next_state;
  always_comb begin
    next_state = state;
    if (bit_valid)
      next_state = state == HUNT   ? (fill_done ? VERIFY : HUNT) :
                   state == VERIFY ? (match && lock_done ? LOCKED : VERIFY) :
                   state == LOCKED ? (lose ? HUNT : LOCKED) : HUNT;
  end
  always_comb locked = in_lock;
  always_ff @(posedge clock) begin
    if (reset) begin
      sr         <= '0;
      fill_cnt   <= '0;
      match_cnt  <= '0;
      win_bits   <= '0;
      win_err    <= '0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      bit_count  <= '0;
      loss_count <= '0;
    end else begin
      err_pulse <= mismatch;
      if (bit_valid) begin
        // flywheel: once locked the register free-runs on its own prediction
        sr        <= {sr[11:0], in_lock ? exp_bit : bit_in};
        fill_cnt  <= state == HUNT ? fill_cnt + 4'd1 : 4'd0;
        match_cnt <= state == VERIFY && match ? match_cnt + MW'(1) : '0;
        win_bits  <= in_lock && !win_end && !lose ? win_bits + WW'(1) : '0;
        win_err   <= in_lock && !win_end && !lose ? win_err_nxt : '0;
      end
      err_count  <= clear_counts ? '0 : mismatch && ~&err_count ? err_count + ERR_W'(1) : err_count;
      bit_count  <= clear_counts ? '0 : bit_valid && in_lock && ~&bit_count ? bit_count + 32'd1 : bit_count;
      loss_count <= clear_counts ? '0 : lose && ~&loss_count ? loss_count + 8'd1 : loss_count;
    end
  end
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb_lfsr_stream_checker: directed scoreboard bench for lfsr_stream_checker.
module tb_lfsr_stream_checker;
  logic        clock = 1'b0, reset = 1'b1, bit_in = 1'b0, bit_valid = 1'b0, clear_counts = 1'b0;
  logic        locked, err_pulse;
  logic [1:0]  state;
  logic [15:0] err_count;
  logic [31:0] bit_count;
  logic [7:0]  loss_count;
  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       pulse;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  logic [12:0] g;
  int seen;
  lfsr_stream_checker dut (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .clear_counts(clear_counts), .locked(locked), .state(state), .err_pulse(err_pulse),
    .err_count(err_count), .bit_count(bit_count), .loss_count(loss_count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  function automatic logic [1:0] est(input int s);
    return s < 13 ? 2'd0 : s < 45 ? 2'd1 : 2'd2;
  endfunction
  task automatic gen(output logic b);
    b = g[12] ^ g[3] ^ g[2] ^ g[0];
    g = {g[11:0], b};
  endtask
  task automatic step(input logic b, input logic v, input logic clr, input logic [1:0] st,
                      input logic pulse, input string tag);
    exp_t e;
    q.push_back('{tag, st, pulse});
    bit_in = b;
    bit_valid = v;
    clear_counts = clr;
    @(posedge clock);
    #1;
    e = q.pop_front();
    chk({e.tag, ".state"}, 32'(state), 32'(e.st));
    chk({e.tag, ".locked"}, 32'(locked), 32'(e.st == 2'd2));
    chk({e.tag, ".err_pulse"}, 32'(err_pulse), 32'(e.pulse));
  endtask
  task automatic do_reset(input string tag);
    reset = 1'b1;
    bit_valid = 1'b0;
    clear_counts = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk({tag, ".rst_state"}, 32'(state), 0);
    chk({tag, ".rst_locked"}, 32'(locked), 0);
    chk({tag, ".rst_pulse"}, 32'(err_pulse), 0);
    chk({tag, ".rst_err"}, 32'(err_count), 0);
    chk({tag, ".rst_bits"}, bit_count, 0);
    chk({tag, ".rst_loss"}, 32'(loss_count), 0);
    g = 13'h000F;
    seen = 0;
  endtask
  task automatic counts(input string tag, input int e, input int b, input int l);
    chk({tag, ".err_count"}, 32'(err_count), 32'(e));
    chk({tag, ".bit_count"}, bit_count, 32'(b));
    chk({tag, ".loss_count"}, 32'(loss_count), 32'(l));
  endtask
  initial begin
    logic b, flip, lost;
    int cyc;
    do_reset("t1");
    for (int i = 0; i < 1000; i++) begin
      gen(b);
      seen++;
      step(b, 1'b1, 1'b0, est(seen), 1'b0, "t1");
    end
    counts("t1", 0, 955, 0);
    do_reset("t2");
    for (int i = 0; i < 1000; i++) begin
      gen(b);
      seen++;
      flip = seen == 146;
      step(b ^ flip, 1'b1, 1'b0, est(seen), flip, "t2");
    end
    counts("t2", 1, 955, 0);
    do_reset("t3");
    lost = 1'b0;
    for (int i = 0; i < 300; i++) begin
      gen(b);
      seen++;
      flip = !lost && seen >= 56 && seen <= 63;
      if (flip && seen == 63) begin
        step(~b, 1'b1, 1'b0, 2'd0, 1'b1, "t3_loss");
        lost = 1'b1;
        seen = 0;
      end else
        step(b ^ flip, 1'b1, 1'b0, est(seen), flip, "t3");
    end
    counts("t3", 8, 210, 1);
    do_reset("t4z");
    for (int i = 0; i < 500; i++) begin
      seen++;
      step(1'b0, 1'b1, 1'b0, seen < 13 ? 2'd0 : 2'd1, 1'b0, "t4z");
    end
    counts("t4z", 0, 0, 0);
    do_reset("t4o");
    for (int i = 0; i < 500; i++) begin
      seen++;
      step(1'b1, 1'b1, 1'b0, seen < 13 ? 2'd0 : 2'd1, 1'b0, "t4o");
    end
    counts("t4o", 0, 0, 0);
    do_reset("t5");
    cyc = 0;
    while (seen < 1000 && cyc < 20000) begin
      cyc++;
      if ($urandom_range(0, 1) == 1) begin
        gen(b);
        seen++;
        step(b, 1'b1, 1'b0, est(seen), 1'b0, "t5");
      end else
        step(1'($urandom_range(0, 1)), 1'b0, 1'b0, est(seen), 1'b0, "t5_idle");
    end
    chk("t5.budget", 32'(seen), 1000);
    counts("t5", 0, 955, 0);
    do_reset("t6");
    for (int i = 0; i < 60; i++) begin
      gen(b);
      seen++;
      step(b, 1'b1, 1'b0, est(seen), 1'b0, "t6");
    end
    gen(b);
    step(~b, 1'b1, 1'b0, 2'd2, 1'b1, "t6_err");
    counts("t6_err", 1, 16, 0);
    gen(b);
    step(~b, 1'b1, 1'b1, 2'd2, 1'b1, "t6_clr");
    counts("t6_clr", 0, 0, 0);
    gen(b);
    step(b, 1'b1, 1'b0, 2'd2, 1'b0, "t6_after");
    counts("t6_after", 0, 1, 0);
    do_reset("t6_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
